// File: rtl/in_frame_fsm_if.sv
// rtl/in_frame_fsm_if.sv - input-stream and FIFO read-side signals of in_frame_fsm
interface in_frame_fsm_if #(
  parameter int DATA_W = 8
);
  logic              i_valid;
  logic [DATA_W-1:0] i_stream;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              i_data_ready;

  modport master (output i_valid, i_stream, i_data_ready, input o_data, o_data_valid);
  modport slave  (input i_valid, i_stream, i_data_ready, output o_data, o_data_valid);
endinterface

// File: rtl/in_frame_fsm.sv
// rtl/in_frame_fsm.sv - sync-hunting framer that commits good payloads atomically into a FIFO
// Define IN_FRAME_FSM_CHECKSUM_EN to expect a trailing XOR checksum word per frame.
module in_frame_fsm #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] SYNC    = 8'hA5,
  parameter int                MAX_LEN = 16,
  parameter int                DEPTH   = 32,
  localparam int               AW      = $clog2(DEPTH),
  localparam int               CW      = AW + 1
) (
  input  logic              clk,
  input  logic              rst_a,
  in_frame_fsm_if.slave     bus,
  output logic              o_event,
  output logic [DATA_W-1:0] o_len,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [CW-1:0]     o_fifo_count
);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_sh_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [DATA_W-1:0] r_len;
  logic [DATA_W-1:0] r_remain;
`ifdef IN_FRAME_FSM_CHECKSUM_EN
  logic [AW-1:0]     r_wr_ptr;
  logic [DATA_W-1:0] r_chk;
`endif

  logic          w_pop;
  logic          w_wr;
  logic          w_commit;
  logic          w_len_bad;
  logic          w_no_room;
  logic [CW-1:0] w_room;

  assign w_pop     = bus.i_data_ready && (o_fifo_count != '0);
  assign w_wr      = bus.i_valid && (r_state == PAYLOAD);
  assign w_room    = CW'(DEPTH) - o_fifo_count;
  assign w_len_bad = (bus.i_stream == '0) || (32'(bus.i_stream) > 32'(MAX_LEN));
  assign w_no_room = 32'(bus.i_stream) > 32'(w_room);

`ifdef IN_FRAME_FSM_CHECKSUM_EN
  assign w_commit = bus.i_valid && (r_state == CHK) && (bus.i_stream == r_chk);
`else
  assign w_commit = bus.i_valid && (r_state == PAYLOAD) && (r_remain == DATA_W'(1));
`endif

  assign bus.o_data       = r_mem[r_rd_ptr];
  assign bus.o_data_valid = (o_fifo_count != '0);

  // Shadow writes land past the committed region; the room check keeps them off unread data.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_sh_ptr] <= bus.i_stream;
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_state      <= IDLE;
      r_sh_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_remain     <= '0;
      o_event      <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= 2'd0;
      o_len        <= '0;
      o_fifo_count <= '0;
`ifdef IN_FRAME_FSM_CHECKSUM_EN
      r_wr_ptr     <= '0;
      r_chk        <= '0;
`endif
    end else begin
      o_event      <= 1'b0;
      o_err        <= 1'b0;
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      o_fifo_count <= o_fifo_count + (w_commit ? CW'(r_len) : '0) - CW'(w_pop);

      if (bus.i_valid) begin
        case (r_state)
          IDLE: begin
            if (bus.i_stream == SYNC) r_state <= LEN;
          end
          LEN: begin
            if (w_len_bad) begin
              o_err      <= 1'b1;
              o_err_code <= 2'd1;
              r_state    <= IDLE;
            end else if (w_no_room) begin
              o_err      <= 1'b1;
              o_err_code <= 2'd2;
              r_state    <= IDLE;
            end else begin
              r_len    <= bus.i_stream;
              r_remain <= bus.i_stream;
`ifdef IN_FRAME_FSM_CHECKSUM_EN
              r_chk    <= bus.i_stream;
`endif
              r_state  <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            r_sh_ptr <= r_sh_ptr + AW'(1);
            r_remain <= r_remain - DATA_W'(1);
`ifdef IN_FRAME_FSM_CHECKSUM_EN
            r_chk    <= r_chk ^ bus.i_stream;
            if (r_remain == DATA_W'(1)) r_state <= CHK;
`else
            if (r_remain == DATA_W'(1)) begin
              o_event <= 1'b1;
              o_len   <= r_len;
              r_state <= IDLE;
            end
`endif
          end
          CHK: begin
`ifdef IN_FRAME_FSM_CHECKSUM_EN
            if (w_commit) begin
              r_wr_ptr <= r_sh_ptr;
              o_event  <= 1'b1;
              o_len    <= r_len;
            end else begin
              r_sh_ptr   <= r_wr_ptr;
              o_err      <= 1'b1;
              o_err_code <= 2'd3;
            end
`endif
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
